// File: rtl/osd_spi_rx.sv
// osd_spi_rx: oversampled mode-0 SPI slave for OSD commands.
// Receives command bytes, drives the OSD enable flag, and streams data
// bytes into the OSD character buffer through a single-cycle write port.
// sck/ss/sdi are asynchronous and sampled on the pixel clock.
module osd_spi_rx #(
  parameter int BUF_AW      = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic              i_sck,
  input  logic              i_ss,
  input  logic              i_sdi,
  output logic              o_osd_enable,
  output logic              o_wr_en,
  output logic [BUF_AW-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_frame_err
);

  // Line select field width inside a command byte (buffer is lines x 256 bytes)
  localparam int LINE_W = BUF_AW - 8;

  // Command opcodes live in the upper five bits of the command byte
  localparam logic [4:0] OP_WRITE  = 5'b00100;
  localparam logic [4:0] OP_ENABLE = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMD     = 2'd1,
    S_WRITE   = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  // Synchroniser chain: bit 2 = sck, bit 1 = ss, bit 0 = sdi.
  // All three travel together so their relative timing is preserved.
  logic [SYNC_STAGES-1:0][2:0] r_sync;

  logic              r_sck_prev;
  logic [6:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  state_t            r_state;
  logic              r_osd_enable;
  logic              r_wr_en;
  logic [BUF_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_frame_err;

  logic              w_sck;
  logic              w_ss;
  logic              w_sdi;
  logic              w_sck_rise;
  logic              w_byte_done;
  logic [7:0]        w_byte;

  // Shift the raw SPI pins through the synchroniser stages
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {i_sck, i_ss, i_sdi}};
    end
  end

  assign w_sck = r_sync[SYNC_STAGES-1][2];
  assign w_ss  = r_sync[SYNC_STAGES-1][1];
  assign w_sdi = r_sync[SYNC_STAGES-1][0];

  // Remember the previous synchronised sck level for edge detection
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_prev <= 1'b0;
    end else begin
      r_sck_prev <= w_sck;
    end
  end

  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_byte      = {r_shift, w_sdi};

  // Protocol FSM: bit assembly, command decode, buffer write strobe, abort handling
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 7'd0;
      r_osd_enable <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 8'h00;
      r_frame_err  <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;

      // Post-increment after each strobe; wraps naturally across line boundaries
      if (r_wr_en) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end

      if (w_ss) begin
        // Deselect aborts from any state; a partial byte is reported, never acted on
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        if (r_bit_cnt != 3'd0) begin
          r_frame_err <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_CMD;
            r_bit_cnt <= 3'd0;
          end

          S_CMD, S_WRITE, S_DISCARD: begin
            if (w_sck_rise) begin
              r_shift   <= {r_shift[5:0], w_sdi};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              case (r_state)
                S_CMD: begin
                  if (w_byte[7:3] == OP_WRITE) begin
                    r_state   <= S_WRITE;
                    r_wr_addr <= {w_byte[LINE_W-1:0], 8'h00};
                  end else if (w_byte[7:3] == OP_ENABLE) begin
                    r_osd_enable <= w_byte[0];
                    r_state      <= S_DISCARD;
                  end else begin
                    r_state <= S_DISCARD;
                  end
                end
                S_WRITE: begin
                  r_wr_data <= w_byte;
                  r_wr_en   <= 1'b1;
                end
                default: begin
                  // Trailing bytes after a non-write command are ignored
                end
              endcase
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_osd_enable = r_osd_enable;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_err  = r_frame_err;

endmodule
